// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle of the UART transmit arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and done.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ack;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic               tx_done;

   modport slave (
      input  req_valid,
      input  req_data,
      input  tx_done,
      output req_ack,
      output tx_start,
      output tx_data
   );

   modport master (
      output req_valid,
      output req_data,
      output tx_done,
      input  req_ack,
      input  tx_start,
      input  tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters,
// with a BUSY-state watchdog that recovers if the transmitter never reports done.
module uart_tx_arbiter #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 200000
) (
   input  logic                clock,
   input  logic                reset,
   uart_tx_arbiter_if.slave    bus,
   output logic                busy,
   output logic [2:0]          grant_idx,
   output logic                byte_sent,
   output logic                timeout_err
);

   localparam int            TW     = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [TW-1:0]      timer;
   logic [7:0]         tx_data_r;
   logic [2:0]         winner;
   logic [7:0]         winner_byte;
   logic               tx_start_c;
   logic [N_REQ-1:0]   req_ack_c;

   // Search starts one past the last grant and wraps, so the last winner has lowest priority.
   function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] valid,
                                          input logic [2:0]       last);
      int idx;
      rr_pick = last;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % N_REQ;
         if (valid[idx]) rr_pick = 3'(idx);
      end
   endfunction

   assign winner      = rr_pick(bus.req_valid, grant_idx);
   assign winner_byte = bus.req_data[8*int'(winner) +: 8];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|bus.req_valid) state_nxt = START;
         START:   state_nxt = BUSY;
         BUSY: begin
            if (bus.tx_done)          state_nxt = DRAIN;
            else if (timer == T_LAST) state_nxt = IDLE;
         end
         // A level-style done must fall before the next arbitration round.
         DRAIN:   if (!bus.tx_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start_c = (state == START);
      busy       = (state != IDLE);
      req_ack_c  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ack_c[i] = (state == START) && (grant_idx == 3'(i));
      end
   end

   assign bus.tx_start = tx_start_c;
   assign bus.req_ack  = req_ack_c;
   assign bus.tx_data  = tx_data_r;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_data_r   <= 8'h00;
         grant_idx   <= 3'(N_REQ - 1);
         timer       <= '0;
         byte_sent   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         // Done wins over a simultaneous watchdog expiry.
         byte_sent   <= (state == BUSY) && bus.tx_done;
         timeout_err <= (state == BUSY) && !bus.tx_done && (timer == T_LAST);
         case (state)
            IDLE: begin
               if (|bus.req_valid) begin
                  tx_data_r <= winner_byte;
                  grant_idx <= winner;
               end
            end
            START: timer <= '0;
            BUSY:  if (timer != T_LAST) timer <= timer + 1'b1;
            default: ;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_ack_with_start: assert property (@(posedge clock) disable iff (!reset)
      (|req_ack_c) == tx_start_c);
   a_done_or_timeout: assert property (@(posedge clock) disable iff (!reset)
      !(byte_sent && timeout_err));
   a_grant_range: assert property (@(posedge clock) disable iff (!reset)
      int'(grant_idx) < N_REQ);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus predicts start/sent/timeout events
// from the arbitration rules, a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;
   localparam int N  = 2;
   localparam int TO = 16;

   localparam int K_START = 0;
   localparam int K_SENT  = 1;
   localparam int K_TOUT  = 2;

   localparam int M_DONE  = 0;
   localparam int M_TOUT  = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       busy;
   logic [2:0] grant_idx;
   logic       byte_sent;
   logic       timeout_err;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .grant_idx  (grant_idx),
      .byte_sent  (byte_sent),
      .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         kind;
      int         cyc;
      int         idx;
      logic [7:0] data;
   } ev_t;

   ev_t exp_q[$];

   logic [N-1:0] pend;
   logic [7:0]   dat [N];
   int           last;
   logic [7:0]   held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int k);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL spurious_event kind=%0d actual=present required=none cycle=%0d", k, cyc);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind",  32'(k),           32'(e.kind));
         check("ev_cycle", 32'(cyc),         32'(e.cyc));
         check("ev_grant", 32'(grant_idx),   32'(e.idx));
         check("ev_data",  32'(bus.tx_data), 32'(e.data));
         if (k == K_START) begin
            check("ack_onehot", 32'(bus.req_ack), 32'(1) << e.idx);
            check("busy_start", 32'(busy),        32'(1));
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (bus.tx_start) expect_ev(K_START);
         if (byte_sent)    expect_ev(K_SENT);
         if (timeout_err)  expect_ev(K_TOUT);
         if (!bus.tx_start) check("ack_idle", 32'(bus.req_ack), 32'(0));
      end
   end

   function automatic int pick(input logic [N-1:0] m, input int l);
      for (int k = 1; k <= N; k++) begin
         if (m[(l + k) % N]) return (l + k) % N;
      end
      return l;
   endfunction

   task automatic drive();
      bus.req_valid = pend;
      for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = dat[i];
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic ev_t mk(input int k, input int c, input int i, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.idx  = i;
      e.data = d;
      return e;
   endfunction

   // Entered in a cycle where the arbiter is known to be IDLE; returns in the next IDLE cycle.
   task automatic run_round(input int mode, input int d, input int len,
                            input bit spur, input bit refill);
      int a, s, e, w, g;
      logic [N-1:0] m;
      check("idle_busy", 32'(busy),        32'(0));
      check("data_hold", 32'(bus.tx_data), 32'(held));
      if (pend == '0) begin
         g = $urandom_range(0, 2);
         repeat (g) step();
         m = '0;
         while (m == '0) m = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if (m[i]) begin
               pend[i] = 1'b1;
               dat[i]  = 8'($urandom);
            end
         end
      end
      drive();
      a    = cyc;
      s    = a + 1;
      w    = pick(pend, last);
      last = w;
      held = dat[w];
      exp_q.push_back(mk(K_START, s, w, dat[w]));
      if (mode == M_TOUT) begin
         exp_q.push_back(mk(K_TOUT, s + TO + 1, w, dat[w]));
         e = s + TO + 1;
      end else begin
         exp_q.push_back(mk(K_SENT, s + d + 1, w, dat[w]));
         e = s + d + len + 1;
      end
      while (cyc < e) begin
         step();
         bus.tx_done = ((mode != M_TOUT) && (cyc >= s + d) && (cyc <= s + d + len - 1))
                       || (spur && cyc == s);
         if (cyc == s + 1) begin
            pend[w] = refill;
            if (!refill) begin
               for (int j = 0; j < N; j++) begin
                  if (!pend[j] && $urandom_range(0, 3) == 0) begin
                     pend[j] = 1'b1;
                     dat[j]  = 8'($urandom);
                  end
               end
            end
            drive();
         end
      end
   endtask

   initial begin
      int mode, d, len;
      bit spur;
      pend        = '0;
      for (int i = 0; i < N; i++) dat[i] = 8'h00;
      bus.tx_done = 1'b0;
      drive();
      last = N - 1;
      held = 8'h00;

      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      check("rst_busy",    32'(busy),         32'(0));
      check("rst_grant",   32'(grant_idx),    32'(N - 1));
      check("rst_txdata",  32'(bus.tx_data),  32'(0));
      check("rst_txstart", 32'(bus.tx_start), 32'(0));
      check("rst_flags",   32'({byte_sent, timeout_err}), 32'(0));
      repeat (3) begin
         step();
         check("idle_start", 32'(bus.tx_start), 32'(0));
         check("idle_busy0", 32'(busy),         32'(0));
      end

      // single request, pulse done 10 cycles after start
      pend = 2'b01; dat[0] = 8'h41;
      run_round(M_DONE, 10, 1, 1'b0, 1'b0);
      pend = '0; drive();

      // level done of 5 cycles with a pending request waiting behind it
      pend = 2'b10; dat[1] = 8'h3C;
      run_round(M_DONE, 3, 5, 1'b0, 1'b1);

      // both continuously valid: rotation 0,1,0,1,...
      pend = 2'b11; dat[0] = 8'hAA; dat[1] = 8'h55;
      repeat (6) run_round(M_DONE, 1, 1, 1'b0, 1'b1);

      // watchdog with another request pending, then done in the final BUSY cycle
      run_round(M_TOUT, 0, 0, 1'b0, 1'b0);
      run_round(M_DONE, TO, 1, 1'b0, 1'b0);
      run_round(M_DONE, TO, 3, 1'b1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         mode = ($urandom_range(0, 7) == 0) ? M_TOUT : M_DONE;
         d    = $urandom_range(1, TO);
         len  = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 5);
         spur = ($urandom_range(0, 3) == 0);
         run_round(mode, d, len, spur, 1'b0);
      end

      // reset while BUSY aborts silently
      pend = 2'b01; dat[0] = 8'h77; drive();
      last = pick(pend, last);
      exp_q.push_back(mk(K_START, cyc + 1, 0, 8'h77));
      step();
      step();
      pend = '0; drive();
      step();
      reset = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy),          32'(0));
      check("mid_rst_start", 32'(bus.tx_start),  32'(0));
      check("mid_rst_ack",   32'(bus.req_ack),   32'(0));
      check("mid_rst_grant", 32'(grant_idx),     32'(N - 1));
      check("mid_rst_data",  32'(bus.tx_data),   32'(0));
      check("mid_rst_queue", 32'(exp_q.size()),  32'(0));
      exp_q.delete();
      last = N - 1;
      held = 8'h00;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         bus.tx_done = (c == 3);
      end
      bus.tx_done = 1'b0;
      check("post_rst_busy", 32'(busy), 32'(0));

      pend = 2'b10; dat[1] = 8'hC3;
      run_round(M_DONE, 2, 1, 1'b0, 1'b0);
      pend = '0; drive();

      repeat (5) step();
      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
      $fatal(1, "bench time limit reached");
   end

endmodule
